// File: rtl/sccb_pkg.sv
// Shared types and constants for the OV7670 SCCB init sequencer.
package sccb_pkg;

  localparam int unsigned SUB_W   = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ENTRY_W = SUB_W + DATA_W;
  localparam int unsigned TIMER_W = 32;

  localparam logic [ENTRY_W-1:0] END_MARKER = 16'hFFFF;
  localparam logic [SUB_W-1:0]   DELAY_SUB  = 8'hFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_RELEASE,
    ST_DELAY,
    ST_DONE,
    ST_ERROR
  } state_t;

  typedef struct packed {
    logic [SUB_W-1:0]  sub;
    logic [DATA_W-1:0] data;
  } entry_t;

  function automatic logic is_end(entry_t e);
    return {e.sub, e.data} == END_MARKER;
  endfunction

  // A 0xFF sub-address is a delay unless the whole entry is the end marker.
  function automatic logic is_delay(entry_t e);
    return (e.sub == DELAY_SUB) && !is_end(e);
  endfunction

endpackage

// File: rtl/sccb_init_sequencer_if.sv
// Request/response bundle between the init sequencer and CoreSCCB.
// SCCB_INIT_READBACK_EN adds the read-data return path.
interface sccb_init_sequencer_if;
  import sccb_pkg::*;

  logic              sccb_start;
  logic              sccb_rw;
  logic [7:0]        sccb_id;
  logic [SUB_W-1:0]  sccb_sub;
  logic [DATA_W-1:0] sccb_wdata;
  logic              sccb_done;
`ifdef SCCB_INIT_READBACK_EN
  logic [DATA_W-1:0] sccb_rdata;

  modport master (output sccb_start, sccb_rw, sccb_id, sccb_sub, sccb_wdata,
                  input  sccb_done, sccb_rdata);
  modport slave  (input  sccb_start, sccb_rw, sccb_id, sccb_sub, sccb_wdata,
                  output sccb_done, sccb_rdata);
`else
  modport master (output sccb_start, sccb_rw, sccb_id, sccb_sub, sccb_wdata,
                  input  sccb_done);
  modport slave  (input  sccb_start, sccb_rw, sccb_id, sccb_sub, sccb_wdata,
                  output sccb_done);
`endif

endinterface

// File: rtl/sccb_init_timer.sv
// Loadable 32-bit down-counter shared by power-up wait, table delays and
// the transaction timeout; expired_c is high while the count sits at zero.
module sccb_init_timer
  import sccb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expired_c
);

  logic [TIMER_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - TIMER_W'(1);
    end
  end

  assign expired_c = (count_q == '0);

endmodule

// File: rtl/sccb_init_sequencer.sv
// OV7670 register-table walker driving CoreSCCB writes with timeouts.
// Build option SCCB_INIT_READBACK_EN: read back and verify every write.
module sccb_init_sequencer
  import sccb_pkg::*;
#(
  parameter int unsigned CLK_FREQ          = 50_000_000,
  parameter logic [7:0]  ID_ADDR           = 8'h42,
  parameter int unsigned TABLE_AW          = 6,
  parameter int unsigned PWRUP_CYCLES      = 50_000,
  parameter int unsigned DELAY_UNIT_CYCLES = 50_000,
  parameter int unsigned TIMEOUT_CYCLES    = 500_000
) (
  input  logic                PCLK,
  input  logic                PRESETN,
  input  logic                init_go,
  output logic                busy,
  output logic                init_done,
  output logic                init_err,
  output logic [TABLE_AW-1:0] err_index,
  output logic [TABLE_AW-1:0] rom_addr,
  input  logic [ENTRY_W-1:0]  rom_data,
  sccb_init_sequencer_if.master bus
);

  if (CLK_FREQ == 0 || TABLE_AW == 0) begin : g_bad_cfg
    $error("sccb_init_sequencer: CLK_FREQ and TABLE_AW must be non-zero");
  end

  localparam logic [7:0] ID_WR = ID_ADDR & 8'hFE;
  localparam logic [7:0] ID_RD = ID_ADDR | 8'h01;
  // Timer counts down to zero inclusive, so load one less than the budget.
  localparam logic [TIMER_W-1:0] TO_LOAD =
    (TIMEOUT_CYCLES > 0) ? TIMER_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t state_q, state_nxt;

  logic                busy_q, busy_nxt;
  logic                done_q, done_nxt;
  logic                err_q, err_nxt;
  logic [TABLE_AW-1:0] err_index_q, err_index_nxt;
  logic [TABLE_AW-1:0] rom_addr_q, rom_addr_nxt;
  logic                start_q, start_nxt;
  logic                rw_q, rw_nxt;
  logic [7:0]          id_q, id_nxt;
  logic [SUB_W-1:0]    sub_q, sub_nxt;
  logic [DATA_W-1:0]   wdata_q, wdata_nxt;
  logic                rd_phase_q, rd_phase_nxt;

  logic               tmr_load_c;
  logic [TIMER_W-1:0] tmr_val_c;
  logic               tmr_expired_c;
  entry_t             entry_c;
  logic               last_c;
  logic               rd_mismatch_c;

  assign entry_c = entry_t'(rom_data);
  assign last_c  = (rom_addr_q == {TABLE_AW{1'b1}});

`ifdef SCCB_INIT_READBACK_EN
  localparam bit READBACK = 1'b1;
  assign rd_mismatch_c = (bus.sccb_rdata != wdata_q);
`else
  localparam bit READBACK = 1'b0;
  assign rd_mismatch_c = 1'b0;
`endif

  sccb_init_timer u_timer (
    .clk       (PCLK),
    .rst_n     (PRESETN),
    .load      (tmr_load_c),
    .load_val  (tmr_val_c),
    .expired_c (tmr_expired_c)
  );

  always_ff @(posedge PCLK) begin
    if (!PRESETN) state_q <= ST_IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:   if (init_go) state_nxt = ST_PWRUP;
      ST_PWRUP:  if (tmr_expired_c) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (is_end(entry_c))        state_nxt = ST_DONE;
        else if (is_delay(entry_c)) state_nxt = ST_DELAY;
        else                        state_nxt = ST_ISSUE;
      end
      ST_ISSUE:  state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (bus.sccb_done)
          state_nxt = (rd_phase_q && rd_mismatch_c) ? ST_ERROR : ST_RELEASE;
        else if (tmr_expired_c)
          state_nxt = ST_ERROR;
      end
      ST_RELEASE: begin
        if (!bus.sccb_done) begin
          if (READBACK && !rd_phase_q) state_nxt = ST_ISSUE;
          else if (last_c)             state_nxt = ST_DONE;
          else                         state_nxt = ST_FETCH;
        end else if (tmr_expired_c) begin
          state_nxt = ST_ERROR;
        end
      end
      ST_DELAY:  if (tmr_expired_c) state_nxt = last_c ? ST_DONE : ST_FETCH;
      ST_DONE:   state_nxt = ST_IDLE;
      ST_ERROR:  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Next values of every registered output plus timer control.
  always_comb begin
    busy_nxt      = busy_q;
    done_nxt      = done_q;
    err_nxt       = err_q;
    err_index_nxt = err_index_q;
    rom_addr_nxt  = rom_addr_q;
    start_nxt     = start_q;
    rw_nxt        = rw_q;
    id_nxt        = id_q;
    sub_nxt       = sub_q;
    wdata_nxt     = wdata_q;
    rd_phase_nxt  = rd_phase_q;
    tmr_load_c    = 1'b0;
    tmr_val_c     = '0;
    case (state_q)
      ST_IDLE: begin
        if (init_go) begin
          busy_nxt      = 1'b1;
          done_nxt      = 1'b0;
          err_nxt       = 1'b0;
          err_index_nxt = '0;
          rom_addr_nxt  = '0;
          tmr_load_c    = 1'b1;
          tmr_val_c     = TIMER_W'(PWRUP_CYCLES);
        end
      end
      ST_DECODE: begin
        if (is_delay(entry_c)) begin
          tmr_load_c = 1'b1;
          tmr_val_c  = TIMER_W'(entry_c.data) * TIMER_W'(DELAY_UNIT_CYCLES);
        end else if (!is_end(entry_c)) begin
          sub_nxt      = entry_c.sub;
          wdata_nxt    = entry_c.data;
          id_nxt       = ID_WR;
          rw_nxt       = 1'b0;
          rd_phase_nxt = 1'b0;
        end
      end
      ST_ISSUE: begin
        start_nxt  = 1'b1;
        tmr_load_c = 1'b1;
        tmr_val_c  = TO_LOAD;
      end
      ST_WAIT_DONE: begin
        if (bus.sccb_done) begin
          start_nxt  = 1'b0;
          tmr_load_c = 1'b1;
          tmr_val_c  = TO_LOAD;
        end else if (tmr_expired_c) begin
          start_nxt = 1'b0;
        end
      end
      ST_RELEASE: begin
        if (!bus.sccb_done) begin
          if (READBACK && !rd_phase_q) begin
            rd_phase_nxt = 1'b1;
            id_nxt       = ID_RD;
            rw_nxt       = 1'b1;
          end else if (!last_c) begin
            rom_addr_nxt = rom_addr_q + TABLE_AW'(1);
          end
        end
      end
      ST_DELAY: begin
        if (tmr_expired_c && !last_c) rom_addr_nxt = rom_addr_q + TABLE_AW'(1);
      end
      ST_DONE: begin
        done_nxt = 1'b1;
        busy_nxt = 1'b0;
      end
      ST_ERROR: begin
        err_nxt       = 1'b1;
        err_index_nxt = rom_addr_q;
        busy_nxt      = 1'b0;
        start_nxt     = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_index_q <= '0;
      rom_addr_q  <= '0;
      start_q     <= 1'b0;
      rw_q        <= 1'b0;
      id_q        <= '0;
      sub_q       <= '0;
      wdata_q     <= '0;
      rd_phase_q  <= 1'b0;
    end else begin
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
      err_q       <= err_nxt;
      err_index_q <= err_index_nxt;
      rom_addr_q  <= rom_addr_nxt;
      start_q     <= start_nxt;
      rw_q        <= rw_nxt;
      id_q        <= id_nxt;
      sub_q       <= sub_nxt;
      wdata_q     <= wdata_nxt;
      rd_phase_q  <= rd_phase_nxt;
    end
  end

  assign busy           = busy_q;
  assign init_done      = done_q;
  assign init_err       = err_q;
  assign err_index      = err_index_q;
  assign rom_addr       = rom_addr_q;
  assign bus.sccb_start = start_q;
  assign bus.sccb_rw    = rw_q;
  assign bus.sccb_id    = id_q;
  assign bus.sccb_sub   = sub_q;
  assign bus.sccb_wdata = wdata_q;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Self-checking bench for sccb_init_sequencer; table-walk model, CoreSCCB
// responder and per-cycle bus monitor. Honours SCCB_INIT_READBACK_EN.
module tb_sccb_init_sequencer;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned PWRUP = 20;
  localparam int unsigned UNIT  = 10;
  localparam int unsigned TMO   = 1000;
  localparam logic [7:0]  ID    = 8'h42;
`ifdef SCCB_INIT_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic          PCLK = 1'b0;
  logic          PRESETN = 1'b0;
  logic          init_go = 1'b0;
  logic          busy, init_done, init_err;
  logic [AW-1:0] err_index, rom_addr;
  logic [15:0]   rom_data;
  logic [15:0]   rom [DEPTH];

  sccb_init_sequencer_if bus ();

  sccb_init_sequencer #(
    .TABLE_AW          (AW),
    .PWRUP_CYCLES      (PWRUP),
    .DELAY_UNIT_CYCLES (UNIT),
    .TIMEOUT_CYCLES    (TMO)
  ) dut (
    .PCLK      (PCLK),
    .PRESETN   (PRESETN),
    .init_go   (init_go),
    .busy      (busy),
    .init_done (init_done),
    .init_err  (init_err),
    .err_index (err_index),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .bus       (bus)
  );

  always #5 PCLK = ~PCLK;

  always_ff @(posedge PCLK) rom_data <= rom[rom_addr];

  // CoreSCCB stand-in: done after resp_lat cycles of start, cleared when start drops.
  int         resp_lat = 200;
  int         stall_abs = -1;
  logic [7:0] bad_sub = 8'hFF;
  int         resp_cnt;
  int         resp_txn;

  always @(posedge PCLK) begin
    if (!PRESETN) begin
      bus.sccb_done <= 1'b0;
      resp_cnt      <= 0;
      resp_txn      <= 0;
`ifdef SCCB_INIT_READBACK_EN
      bus.sccb_rdata <= 8'h00;
`endif
    end else if (bus.sccb_start && !bus.sccb_done) begin
      if (resp_txn != stall_abs) begin
        if (resp_cnt + 1 >= resp_lat) begin
          bus.sccb_done <= 1'b1;
          resp_cnt      <= 0;
          resp_txn      <= resp_txn + 1;
`ifdef SCCB_INIT_READBACK_EN
          bus.sccb_rdata <= bus.sccb_wdata ^ ((bus.sccb_sub == bad_sub) ? 8'h01 : 8'h00);
`endif
        end else begin
          resp_cnt <= resp_cnt + 1;
        end
      end
    end else if (!bus.sccb_start) begin
      bus.sccb_done <= 1'b0;
      resp_cnt      <= 0;
    end
  end

  int          errors = 0;
  int          checks = 0;
  logic [24:0] exp_q[$];
  logic [24:0] obs[$];
  int          mon_n = 0;
  int          last_hi = 0;
  int          first_move = -1;
  logic        exp_err;
  int          exp_idx;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // Expected transaction list straight from the table encoding rules.
  task automatic build_model(int stall_txn);
    int n;
    logic [15:0] e;
    n = 0;
    exp_q.delete();
    exp_err = 1'b0;
    exp_idx = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      e = rom[i];
      if (e == 16'hFFFF) break;
      if (e[15:8] == 8'hFF) continue;
      exp_q.push_back({ID & 8'hFE, 1'b0, e[15:8], e[7:0]});
      if (n == stall_txn) begin exp_err = 1'b1; exp_idx = i; break; end
      n++;
      if (RB) begin
        exp_q.push_back({ID | 8'h01, 1'b1, e[15:8], e[7:0]});
        if (n == stall_txn || e[15:8] == bad_sub) begin exp_err = 1'b1; exp_idx = i; break; end
        n++;
      end
    end
  endtask

  // Per-cycle bus checks: transaction content, operand hold, start spacing.
  task automatic monitor();
    logic [24:0] cur, held;
    logic        prev;
    int          low_run, hi_run;
    prev = 1'b0; low_run = 100; hi_run = 0; held = '0;
    forever begin
      @(negedge PCLK);
      cur = {bus.sccb_id, bus.sccb_rw, bus.sccb_sub, bus.sccb_wdata};
      if (bus.sccb_start && !prev) begin
        chk("start_gap", 32'(low_run >= 2), 1);
        if (mon_n < exp_q.size()) begin
          chk("txn", 32'(cur), 32'(exp_q[mon_n]));
        end else begin
          checks++; errors++;
          $display("FAIL txn_extra: got 0x%0h, expected no transaction", cur);
        end
        obs.push_back(cur);
        mon_n++;
        held = cur;
        hi_run = 1;
      end else if (bus.sccb_start) begin
        chk("operand_hold", 32'(cur), 32'(held));
        hi_run++;
      end
      if (bus.sccb_start) chk("start_busy", 32'(busy), 1);
      if (!bus.sccb_start && prev) last_hi = hi_run;
      if (bus.sccb_start) low_run = 0; else low_run++;
      prev = bus.sccb_start;
    end
  endtask

  task automatic set_table(logic [15:0] t[$]);
    for (int i = 0; i < int'(DEPTH); i++) rom[i] = (i < t.size()) ? t[i] : 16'hFFFF;
  endtask

  task automatic run_seq(string tag, int stall_txn, int lat, int go_again);
    int n;
    build_model(stall_txn);
    resp_lat   = lat;
    stall_abs  = (stall_txn < 0) ? -1 : resp_txn + stall_txn;
    mon_n      = 0;
    obs.delete();
    first_move = -1;
    init_go = 1'b1; tick(1); init_go = 1'b0;
    chk({tag, "_busy_on"}, 32'(busy), 1);
    n = 0;
    while (busy && n < 40000) begin
      if (n == go_again) init_go = 1'b1;
      tick(1);
      init_go = 1'b0;
      if (first_move < 0 && rom_addr != '0) first_move = n;
      n++;
    end
    chk({tag, "_finished"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(init_done), 32'(!exp_err));
    chk({tag, "_err"}, 32'(init_err), 32'(exp_err));
    chk({tag, "_err_index"}, 32'(err_index), 32'(exp_idx));
    chk({tag, "_txn_count"}, 32'(mon_n), 32'(exp_q.size()));
  endtask

  initial begin
    logic [15:0] t[$];
    int n;
    fork monitor(); join_none

    for (int i = 0; i < int'(DEPTH); i++) rom[i] = 16'hFFFF;
    tick(3);
    chk("rst_status", 32'({busy, init_done, init_err}), 0);
    chk("rst_idx", 32'({err_index, rom_addr}), 0);
    chk("rst_bus", 32'({bus.sccb_start, bus.sccb_rw, bus.sccb_id, bus.sccb_sub, bus.sccb_wdata}), 0);
    PRESETN = 1'b1;
    tick(2);

    // two writes, 200-cycle responder
    t = '{16'h1280, 16'h1101, 16'hFFFF};
    set_table(t);
    run_seq("two_wr", -1, 200, -1);
    chk("two_wr_n", 32'(mon_n), RB ? 4 : 2);
    if (obs.size() >= (RB ? 3 : 2)) begin
      chk("two_wr_first", 32'(obs[0]), 32'({8'h42, 1'b0, 8'h12, 8'h80}));
      chk("two_wr_second", 32'(obs[RB ? 2 : 1]), 32'({8'h42, 1'b0, 8'h11, 8'h01}));
    end
    chk("two_wr_flags", 32'({init_done, busy}), 32'(2'b10));

    // delay entry only
    t = '{16'hFF0A, 16'hFFFF};
    set_table(t);
    run_seq("delay", -1, 10, -1);
    chk("delay_gap", 32'(first_move >= int'(PWRUP + 10 * UNIT)), 1);
    chk("delay_no_txn", 32'(mon_n), 0);
    chk("delay_done", 32'(init_done), 1);

    // timeout on entry 3
    t = '{16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h5005, 16'hFFFF};
    set_table(t);
    run_seq("timeout", RB ? 6 : 3, 20, -1);
    chk("timeout_err", 32'({init_err, init_done}), 32'(2'b10));
    chk("timeout_idx", 32'(err_index), 3);
    chk("timeout_len", 32'(last_hi >= int'(TMO) && last_hi <= int'(TMO) + 2), 1);
    chk("timeout_start_low", 32'(bus.sccb_start), 0);

    // go pulse mid-sequence is ignored
    t = '{16'h1280, 16'h1101, 16'hFFFF};
    set_table(t);
    run_seq("go_busy", -1, 50, 150);
    chk("go_busy_n", 32'(mon_n), RB ? 4 : 2);

    // reset inside WAIT_DONE, then restart from entry 0
    build_model(-1);
    resp_lat = 200; stall_abs = -1; mon_n = 0; obs.delete();
    init_go = 1'b1; tick(1); init_go = 1'b0;
    n = 0;
    while (!bus.sccb_start && n < 500) begin tick(1); n++; end
    chk("rst_saw_start", 32'(bus.sccb_start), 1);
    tick(5);
    PRESETN = 1'b0; tick(1); PRESETN = 1'b1;
    chk("rst_mid_start", 32'(bus.sccb_start), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_addr", 32'(rom_addr), 0);
    tick(2);
    run_seq("restart", -1, 30, -1);
    if (obs.size() > 0) chk("restart_first", 32'(obs[0]), 32'({8'h42, 1'b0, 8'h12, 8'h80}));

    // full table, no end marker; zero-length delay at entry 0
    t.delete();
    t.push_back(16'hFF00);
    for (int i = 1; i < int'(DEPTH); i++) t.push_back({8'(8'h10 + i), 8'(i)});
    set_table(t);
    run_seq("full", -1, 5, -1);
    chk("full_n", 32'(mon_n), RB ? 30 : 15);
    chk("full_addr", 32'(rom_addr), 32'(4'hF));

`ifdef SCCB_INIT_READBACK_EN
    // readback mismatch on 3A
    bad_sub = 8'h3A;
    t = '{16'h1280, 16'h3A04, 16'hFFFF};
    set_table(t);
    run_seq("rb", -1, 20, -1);
    chk("rb_n", 32'(mon_n), 4);
    if (obs.size() >= 4) chk("rb_read", 32'(obs[3]), 32'({8'h43, 1'b1, 8'h3A, 8'h04}));
    chk("rb_err", 32'({init_err, err_index}), 32'({1'b1, 4'd1}));
    bad_sub = 8'hFF;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
